sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Two-port request arbiter in front of the SDRAM burst engine (write/read sequencers behind the SDRAM top-level arbitration FSM). Each client port (e.g. UART-RX write path, UART-TX read path) submits one burst request carrying direction and a linear address. The block serialises the requests onto a single command channel with round-robin fairness. No new command is issued while the refresh controller is requesting. It also tracks the outstanding burst and raises a sticky timeout if the engine never completes it.

## Interface
Parameters:
- ADDR_W, 22, linear burst address width: {bank[1:0], row[11:0], col[7:0]}
- TIMEOUT, 1023, max cycles from command accept to cmd_done before timeout is flagged

Ports (x = 0, 1):
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_x  in  1  port x request; level, held until gnt_x
- req_we_x  in  1  port x direction: 1 = write burst, 0 = read burst
- req_addr_x  in  ADDR_W  port x burst start address; stable while req_x high
- gnt_x  out  1  one-cycle pulse: port x request latched
- done_x  out  1  one-cycle pulse: port x burst finished or timed out
- ref_rq  in  1  refresh controller request; blocks new grants
- cmd_valid  out  1  command to burst engine valid
- cmd_we  out  1  latched direction
- cmd_addr  out  ADDR_W  latched address
- cmd_ready  in  1  engine accepts command when cmd_valid & cmd_ready
- cmd_done  in  1  one-cycle pulse: engine burst complete
- busy  out  1  high in any state other than IDLE
- timeout  out  1  sticky error flag; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_DONE. Encoding is free.
- Reset values:
  - state = IDLE.
  - gnt_x, done_x, cmd_valid, cmd_we, busy and timeout = 0.
  - cmd_addr = 0.
  - Round-robin pointer rr = 0, meaning port 0 is preferred.
- IDLE:
  - With ref_rq = 0 and at least one req_x = 1, select a port:
    - Only one requesting: that port.
    - Both requesting: port rr.
  - On the same edge: latch req_we/req_addr into cmd_we/cmd_addr, pulse gnt_x for the next cycle, record the owner, and go to ISSUE.
  - ref_rq = 1: stay in IDLE; no grant is issued.
- ISSUE:
  - cmd_valid = 1. cmd_we and cmd_addr are held constant.
  - ref_rq has no effect here; a valid command is never withdrawn.
  - On cmd_ready = 1: clear cmd_valid, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - On cmd_done = 1: pulse done_owner for the next cycle, set rr = ~owner, go to IDLE.
  - If the counter reaches TIMEOUT before cmd_done: set timeout = 1, pulse done_owner, set rr = ~owner, go to IDLE.
  - A cmd_done arriving while not in WAIT_DONE is ignored.
- A cmd_done and a timeout on the same cycle count as done; timeout is not set.
- Counter is $clog2(TIMEOUT+1) bits wide and saturates; it does not wrap.
- Clients must not re-raise req_x between their gnt_x and done_x. A request raised in that window stays pending until IDLE and is not lost.

## Timing
- Request to grant:
  - req_x sampled in IDLE at edge N; gnt_x high during cycle N+1.
  - cmd_valid also rises in cycle N+1 (ISSUE entered at edge N).
- Minimum turnaround:
  - cmd_ready already high → accepted at edge N+1, WAIT_DONE from N+1.
  - cmd_done at edge M → done_x high in cycle M+1 and IDLE in M+1.
  - Next grant sampled at edge M+1, earliest gnt in M+2; one idle cycle between bursts.
- ref_rq blocking:
  - ref_rq rising in the same cycle as a req blocks that grant.
  - ref_rq falling lets the grant be sampled on the next edge.
- Async reset mid-operation: all outputs drop immediately. The outstanding burst is abandoned with no done_x pulse.
- gnt_x and done_x are never high on both ports in the same cycle.

## Test plan
- **Single request.** req_0 = 1, we = 1, addr = 0x12345, cmd_ready = 1.
  - gnt_0 one cycle after req.
  - cmd_valid for 1 cycle with cmd_addr = 0x12345, cmd_we = 1.
  - cmd_done after 8 cycles → done_0 the next cycle; busy low afterwards.
- **Simultaneous requests, round-robin.** req_0 = req_1 = 1 held continuously for 4 bursts.
  - Grants come in order 0, 1, 0, 1.
  - Each done_x precedes the next gnt by ≥ 1 cycle.
- **Refresh blocking.** ref_rq = 1 for 20 cycles while req_1 = 1.
  - No gnt_1 and cmd_valid = 0 throughout.
  - gnt_1 appears one cycle after ref_rq falls.
- **Backpressure.** cmd_ready = 0 for 5 cycles after grant.
  - cmd_valid is held 5 cycles with stable cmd_addr/cmd_we.
  - Accept on cycle 6.
  - ref_rq asserted during the wait does not drop cmd_valid.
- **Timeout.** TIMEOUT = 15, cmd_done never pulses.
  - timeout = 1 and done_owner pulse 15 cycles after accept; return to IDLE.
  - timeout stays 1 through later successful bursts.
- **Reset mid-burst.** rst_n low during WAIT_DONE.
  - All outputs 0 immediately; rr = 0; no done pulse.
  - After release, simultaneous requests grant port 0 first.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_port_arbiter                                                       |
// | Two-port round-robin burst request arbiter with refresh blocking and     |
// | outstanding-burst timeout for the SDRAM burst engine.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_we_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic              req_1,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              done_0,
  output logic              done_1,
  input  logic              ref_rq,
  output logic              cmd_valid,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic              busy,
  output logic              timeout
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rr;
  logic              r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic              r_timeout;

  logic w_sel;
  logic w_grant;
  logic w_accept;
  logic w_finish;
  logic w_expire;

  always_comb begin
    w_state_next = r_state;
    w_sel        = r_rr;
    w_grant      = 1'b0;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ref_rq && (req_0 || req_1)) begin
          w_grant      = 1'b1;
          w_sel        = (req_0 && req_1) ? r_rr : req_1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A completion on the expiry cycle wins, so the error flag stays clear.
        if (cmd_done) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt >= C_CNT_LAST) begin
          w_finish     = 1'b1;
          w_expire     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= 1'b0;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_cmd_we   <= 1'b0;
      r_cmd_addr <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      if (w_grant) begin
        r_cmd_we     <= w_sel ? req_we_1 : req_we_0;
        r_cmd_addr   <= w_sel ? req_addr_1 : req_addr_0;
        r_owner      <= w_sel;
        r_gnt[w_sel] <= 1'b1;
      end
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_DONE && r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_finish) begin
        r_done[r_owner] <= 1'b1;
        r_rr            <= ~r_owner;
      end
      if (w_expire) r_timeout <= 1'b1;
    end
  end

  assign gnt_0     = r_gnt[0];
  assign gnt_1     = r_gnt[1];
  assign done_0    = r_done[0];
  assign done_1    = r_done[1];
  assign cmd_valid = (r_state == S_ISSUE);
  assign cmd_we    = r_cmd_we;
  assign cmd_addr  = r_cmd_addr;
  assign busy      = (r_state != S_IDLE);
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdram_port_arbiter                                                    |
// | Scenario tests plus randomized bursts against a transaction-level model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sdram_port_arbiter;

  localparam int ADDR_W  = 22;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic              req_0, req_1, req_we_0, req_we_1;
  logic [ADDR_W-1:0] req_addr_0, req_addr_1;
  logic              gnt_0, gnt_1, done_0, done_1;
  logic              ref_rq, cmd_valid, cmd_we, cmd_ready, cmd_done, busy, timeout;
  logic [ADDR_W-1:0] cmd_addr;

  int n_tests;
  int n_fail;
  int cyc;

  // Transaction-level model: pending requests per port, fairness pointer, sticky error.
  logic              m_rr;
  logic              m_timeout;
  logic              m_pend [2];
  logic              m_we   [2];
  logic [ADDR_W-1:0] m_addr [2];

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_we_0(req_we_0), .req_addr_0(req_addr_0),
    .req_1(req_1), .req_we_1(req_we_1), .req_addr_1(req_addr_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .ref_rq(ref_rq), .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .busy(busy), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs;
    req_0 = 0; req_1 = 0; req_we_0 = 0; req_we_1 = 0;
    req_addr_0 = '0; req_addr_1 = '0;
    ref_rq = 0; cmd_ready = 0; cmd_done = 0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    m_rr = 0; m_timeout = 0;
    for (int q = 0; q < 2; q++) begin
      m_pend[q] = 0; m_we[q] = 0; m_addr[q] = '0;
    end
  endtask

  task automatic apply_ports;
    req_0 = m_pend[0]; req_we_0 = m_we[0]; req_addr_0 = m_addr[0];
    req_1 = m_pend[1]; req_we_1 = m_we[1]; req_addr_1 = m_addr[1];
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    #3;
    n_tests++;
    if ({gnt_0, gnt_1, done_0, done_1, cmd_valid, cmd_we, busy, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {gnt_0, gnt_1, done_0, done_1, cmd_valid, cmd_we, busy, timeout});
    end
    n_tests++;
    if (cmd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected 0", cmd_addr);
    end
    tick(); tick();
    rst_n = 1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b cmd_valid=%b expected 0 0", busy, cmd_valid);
    end
  endtask

  task automatic test_single;
    req_0 = 1; req_we_0 = 1; req_addr_0 = 22'h12345; cmd_ready = 1;
    tick();
    n_tests++;
    if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt: gnt_0=%b gnt_1=%b expected 1 0", gnt_0, gnt_1);
    end
    n_tests++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 22'h12345 || cmd_we !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cmd: valid=%b addr=%h we=%b expected 1 12345 1", cmd_valid, cmd_addr, cmd_we);
    end
    req_0 = 0;
    tick();
    n_tests++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1 || gnt_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: valid=%b busy=%b gnt_0=%b expected 0 1 0", cmd_valid, busy, gnt_0);
    end
    repeat (7) tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
    n_tests++;
    if (done_0 !== 1'b1 || done_1 !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done_0=%b done_1=%b busy=%b expected 1 0 0", done_0, done_1, busy);
    end
    tick();
    n_tests++;
    if (done_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: done_0=%b expected 0", done_0);
    end
    cmd_done = 1;
    tick();
    cmd_done = 0;
    n_tests++;
    if (done_0 !== 1'b0 || done_1 !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done_idle: done=%b%b busy=%b expected 00 0", done_1, done_0, busy);
    end
  endtask

  task automatic test_round_robin;
    int port;
    int done_cyc;
    logic found;
    apply_reset();
    req_0 = 1; req_1 = 1; req_we_0 = 0; req_we_1 = 1;
    req_addr_0 = 22'h0AAAA; req_addr_1 = 22'h15555; cmd_ready = 1;
    done_cyc = 0;
    for (int b = 0; b < 4; b++) begin
      found = 0;
      port = 0;
      for (int t = 0; t < 10; t++) begin
        tick();
        if (gnt_0 === 1'b1 || gnt_1 === 1'b1) begin
          found = 1;
          break;
        end
      end
      n_tests++;
      if (!found) begin
        n_fail++;
        $display("FAIL rr_gnt_timeout: burst %0d got no grant within 10 cycles", b);
      end
      port = (gnt_1 === 1'b1) ? 1 : 0;
      n_tests++;
      if ({gnt_1, gnt_0} !== ((b % 2) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_order: burst %0d gnt=%b%b expected port %0d", b, gnt_1, gnt_0, b % 2);
      end
      if (b > 0) begin
        n_tests++;
        if (cyc - done_cyc != 1) begin
          n_fail++;
          $display("FAIL rr_turnaround: burst %0d gap=%0d expected 1", b, cyc - done_cyc);
        end
      end
      n_tests++;
      if (cmd_addr !== (port ? 22'h15555 : 22'h0AAAA)) begin
        n_fail++;
        $display("FAIL rr_addr: burst %0d addr=%h", b, cmd_addr);
      end
      tick();
      tick(); tick();
      cmd_done = 1;
      tick();
      cmd_done = 0;
      done_cyc = cyc;
      n_tests++;
      if ({done_1, done_0} !== (port ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_done: burst %0d done=%b%b expected port %0d", b, done_1, done_0, port);
      end
    end
    req_0 = 0; req_1 = 0;
    tick();
  endtask

  task automatic test_refresh;
    logic blocked_ok;
    ref_rq = 1; req_1 = 1; req_we_1 = 0; req_addr_1 = 22'h2F00F; cmd_ready = 1;
    blocked_ok = 1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (gnt_1 !== 1'b0 || cmd_valid !== 1'b0) blocked_ok = 0;
    end
    n_tests++;
    if (!blocked_ok) begin
      n_fail++;
      $display("FAIL refresh_block: grant or cmd_valid seen while ref_rq high, expected none");
    end
    ref_rq = 0;
    tick();
    n_tests++;
    if (gnt_1 !== 1'b1 || cmd_addr !== 22'h2F00F) begin
      n_fail++;
      $display("FAIL refresh_release: gnt_1=%b addr=%h expected 1 2f00f", gnt_1, cmd_addr);
    end
    req_1 = 0;
    tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
    n_tests++;
    if (done_1 !== 1'b1) begin
      n_fail++;
      $display("FAIL refresh_done: done_1=%b expected 1", done_1);
    end
  endtask

  task automatic test_backpressure;
    logic hold_ok;
    req_0 = 1; req_we_0 = 0; req_addr_0 = 22'h3ABCDE; cmd_ready = 0;
    tick();
    n_tests++;
    if (gnt_0 !== 1'b1 || cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_gnt: gnt_0=%b valid=%b expected 1 1", gnt_0, cmd_valid);
    end
    req_0 = 0;
    hold_ok = 1;
    for (int t = 1; t < 5; t++) begin
      if (t == 2) ref_rq = 1;
      cmd_done = (t == 1);
      tick();
      cmd_done = 0;
      if (cmd_valid !== 1'b1 || cmd_addr !== 22'h3ABCDE || cmd_we !== 1'b0 || done_0 !== 1'b0) hold_ok = 0;
    end
    n_tests++;
    if (!hold_ok) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b addr=%h we=%b done_0=%b expected 1 3abcde 0 0",
               cmd_valid, cmd_addr, cmd_we, done_0);
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    n_tests++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b busy=%b expected 0 1", cmd_valid, busy);
    end
    ref_rq = 0;
    tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
    n_tests++;
    if (done_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: done_0=%b expected 1", done_0);
    end
  endtask

  task automatic test_done_at_expiry;
    apply_reset();
    req_1 = 1; req_addr_1 = 22'h00777; cmd_ready = 1;
    tick();
    req_1 = 0;
    tick();
    repeat (TIMEOUT - 1) tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
    n_tests++;
    if (done_1 !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL done_at_expiry: done_1=%b timeout=%b expected 1 0", done_1, timeout);
    end
  endtask

  task automatic test_timeout;
    logic early;
    req_1 = 1; req_addr_1 = 22'h01234; cmd_ready = 1;
    tick();
    req_1 = 0;
    tick();
    early = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      if (done_1 !== 1'b0 || timeout !== 1'b0) early = 1;
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL timeout_early: done or timeout before %0d cycles, expected none", TIMEOUT);
    end
    tick();
    n_tests++;
    if (done_1 !== 1'b1 || timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: done_1=%b timeout=%b busy=%b expected 1 1 0", done_1, timeout, busy);
    end
    req_0 = 1; req_addr_0 = 22'h04321;
    tick();
    req_0 = 0;
    tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
    n_tests++;
    if (done_0 !== 1'b1 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: done_0=%b timeout=%b expected 1 1", done_0, timeout);
    end
  endtask

  task automatic test_reset_mid;
    logic no_done;
    apply_reset();
    cmd_ready = 1;
    req_0 = 1; req_addr_0 = 22'h00100;
    tick();
    req_0 = 0;
    tick();
    cmd_done = 1;
    tick();
    cmd_done = 0;
    req_1 = 1; req_we_1 = 1; req_addr_1 = 22'h3FFFFF;
    tick();
    req_1 = 0;
    tick(); tick(); tick();
    #2;
    rst_n = 0;
    #1;
    n_tests++;
    if ({gnt_0, gnt_1, done_0, done_1, cmd_valid, cmd_we, busy, timeout} !== 8'b0 || cmd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: flags=%b addr=%h expected 00000000 0",
               {gnt_0, gnt_1, done_0, done_1, cmd_valid, cmd_we, busy, timeout}, cmd_addr);
    end
    cmd_done = 1;
    tick();
    cmd_done = 0;
    rst_n = 1;
    no_done = 1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (done_0 !== 1'b0 || done_1 !== 1'b0 || busy !== 1'b0) no_done = 0;
    end
    n_tests++;
    if (!no_done) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: done or busy seen after reset, expected none");
    end
    req_0 = 1; req_1 = 1;
    tick();
    n_tests++;
    if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rr: gnt_0=%b gnt_1=%b expected 1 0", gnt_0, gnt_1);
    end
  endtask

  task automatic test_random;
    int   p;
    int   rdly;
    int   dedge;
    int   exp_edge;
    logic to_exp;
    logic blocked_ok;
    logic hold_ok;
    logic early;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      for (int q = 0; q < 2; q++) begin
        if (!m_pend[q] && $urandom_range(0, 1) == 1) begin
          m_pend[q] = 1;
          m_we[q]   = 1'($urandom_range(0, 1));
          m_addr[q] = ADDR_W'($urandom);
        end
      end
      if (!m_pend[0] && !m_pend[1]) begin
        p = $urandom_range(0, 1);
        m_pend[p] = 1;
        m_we[p]   = 1'($urandom_range(0, 1));
        m_addr[p] = ADDR_W'($urandom);
      end
      apply_ports();
      p = (m_pend[0] && m_pend[1]) ? int'(m_rr) : (m_pend[1] ? 1 : 0);

      rdly = $urandom_range(0, 3);
      ref_rq = (rdly != 0);
      blocked_ok = 1;
      for (int t = 0; t < rdly; t++) begin
        tick();
        if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0 || cmd_valid !== 1'b0) blocked_ok = 0;
      end
      ref_rq = 0;
      tick();
      n_tests++;
      if (!blocked_ok) begin
        n_fail++;
        $display("FAIL rnd_refresh: iter %0d grant while ref_rq high", it);
      end
      n_tests++;
      if ({gnt_1, gnt_0} !== (p ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rnd_gnt: iter %0d gnt=%b%b expected port %0d", it, gnt_1, gnt_0, p);
      end
      n_tests++;
      if (cmd_valid !== 1'b1 || cmd_addr !== m_addr[p] || cmd_we !== m_we[p]) begin
        n_fail++;
        $display("FAIL rnd_cmd: iter %0d valid=%b addr=%h we=%b expected 1 %h %b",
                 it, cmd_valid, cmd_addr, cmd_we, m_addr[p], m_we[p]);
      end
      m_pend[p] = 0;
      apply_ports();

      rdly = $urandom_range(0, 3);
      hold_ok = 1;
      for (int t = 0; t < rdly; t++) begin
        cmd_ready = 0;
        ref_rq = 1'($urandom_range(0, 1));
        tick();
        if (cmd_valid !== 1'b1 || cmd_addr !== m_addr[p] || cmd_we !== m_we[p]) hold_ok = 0;
      end
      ref_rq = 0;
      cmd_ready = 1;
      tick();
      cmd_ready = 0;
      n_tests++;
      if (!hold_ok || cmd_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_accept: iter %0d hold_ok=%b valid=%b busy=%b expected 1 0 1",
                 it, hold_ok, cmd_valid, busy);
      end

      dedge    = $urandom_range(1, 20);
      to_exp   = (dedge > TIMEOUT);
      exp_edge = to_exp ? TIMEOUT : dedge;
      early = 0;
      for (int k = 1; k <= exp_edge; k++) begin
        cmd_done = (k == dedge);
        tick();
        cmd_done = 0;
        if (k < exp_edge && (done_0 !== 1'b0 || done_1 !== 1'b0)) early = 1;
      end
      m_timeout = m_timeout | to_exp;
      m_rr = (p == 0);
      n_tests++;
      if (early || {done_1, done_0} !== (p ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rnd_done: iter %0d early=%b done=%b%b expected port %0d at edge %0d",
                 it, early, done_1, done_0, p, exp_edge);
      end
      n_tests++;
      if (timeout !== m_timeout || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_timeout: iter %0d timeout=%b busy=%b expected %b 0", it, timeout, busy, m_timeout);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_refresh();
    test_backpressure();
    test_done_at_expiry();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
